// File: rtl/vga_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_flash_reader
// Brief    : Fetches 16-bit words from parallel NOR flash for the VGA preload
//            port using one timed read cycle per requested word.
// Revision : 1.0 - initial release
// ============================================================================
module vga_flash_reader #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_re,
    input  logic [22:0] vga_addr,
    output logic [15:0] vga_data,
    output logic        vga_success,
    output logic [22:0] flash_a,
    input  logic [15:0] flash_d,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic        flash_byte_n,
    output logic        flash_rp_n
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] c_last_cnt = 4'(WAIT_CYCLES - 1);

    state_t      state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [21:0] addr_q,    addr_d;
    logic [15:0] data_q,    data_d;
    logic        success_q, success_d;
    logic        en_n_q,    en_n_d;
    logic        rp_n_q;

    // Bit 0 selects a byte inside the word we already hold; it never matters here.
    logic w_unused;
    assign w_unused = vga_addr[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        success_d = success_q;
        en_n_d    = en_n_q;

        unique case (state_q)
            S_IDLE: begin
                success_d = 1'b0;
                en_n_d    = 1'b1;
                if (vga_re) begin
                    addr_d  = vga_addr[22:1];
                    en_n_d  = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end
            end

            S_ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (!vga_re) begin
                    en_n_d    = 1'b1;
                    success_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (cnt_q == c_last_cnt) begin
                    data_d    = flash_d;
                    success_d = 1'b1;
                    en_n_d    = 1'b1;
                    state_d   = S_HOLD;
                end
            end

            S_HOLD: begin
                if (!vga_re) begin
                    success_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (vga_addr[22:1] != addr_q) begin
                    // Next word starts on this same edge to keep the stream dense.
                    success_d = 1'b0;
                    addr_d    = vga_addr[22:1];
                    en_n_d    = 1'b0;
                    cnt_d     = 4'd0;
                    state_d   = S_ACCESS;
                end
            end

            default: begin
                success_d = 1'b0;
                en_n_d    = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 22'd0;
            data_q    <= 16'd0;
            success_q <= 1'b0;
            en_n_q    <= 1'b1;
            rp_n_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            success_q <= success_d;
            en_n_q    <= en_n_d;
            rp_n_q    <= 1'b1;
        end
    end

    assign vga_data     = data_q;
    assign vga_success  = success_q;
    assign flash_a      = {addr_q, 1'b0};
    assign flash_ce_n   = en_n_q;
    assign flash_oe_n   = en_n_q;
    assign flash_we_n   = 1'b1;
    assign flash_byte_n = 1'b1;
    assign flash_rp_n   = rp_n_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_flash_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_flash_reader
// Brief    : Self-checking bench for vga_flash_reader with a timed flash model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_flash_reader;

    localparam int W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_re = 1'b0;
    logic [22:0] vga_addr = 23'd0;
    logic [15:0] vga_data;
    logic        vga_success;
    logic [22:0] flash_a;
    logic [15:0] flash_d;
    logic        flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n, flash_rp_n;

    int total = 0;
    int bad   = 0;

    vga_flash_reader #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .vga_re(vga_re), .vga_addr(vga_addr),
        .vga_data(vga_data), .vga_success(vga_success), .flash_a(flash_a),
        .flash_d(flash_d), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
        .flash_we_n(flash_we_n), .flash_byte_n(flash_byte_n), .flash_rp_n(flash_rp_n)
    );

    always #5 clk = ~clk;

    // Flash contents: word at byte address a is a[16:1] ^ 0xA5A5.
    function automatic logic [15:0] model(input logic [22:0] a);
        return a[16:1] ^ 16'hA5A5;
    endfunction

    // Bus only carries valid data once enables have been low long enough (tACC).
    int oe_cnt = 0;
    always @(posedge clk) oe_cnt <= (!flash_ce_n && !flash_oe_n) ? oe_cnt + 1 : 0;
    assign flash_d = (!flash_ce_n && !flash_oe_n && oe_cnt >= W - 1) ? model(flash_a) : 16'hxxxx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Consumer-side invariants: data frozen while valid, address frozen while reading.
    logic        p_succ = 1'b0, p_oe_low = 1'b0;
    logic [15:0] p_data = 16'd0;
    logic [22:0] p_a = 23'd0;
    always @(negedge clk) begin
        if (!rst && p_succ && vga_success) check("hold_data_stable", {16'd0, vga_data}, {16'd0, p_data});
        if (!rst && p_oe_low && !flash_oe_n) check("addr_stable", {9'd0, flash_a}, {9'd0, p_a});
        p_succ   = (vga_success === 1'b1);
        p_oe_low = (flash_oe_n === 1'b0);
        p_data   = vga_data;
        p_a      = flash_a;
    end

    logic [15:0] last_word = 16'd0;

    // Request for word a is presented now; the next edge samples it.
    task automatic wait_word(input logic [22:0] a, input int chg_tick, input logic [22:0] chg_addr);
        int lat, low;
        bit got;
        lat = 0; low = 0; got = 0;
        for (int i = 0; i < W + 8 && !got; i++) begin
            tick();
            lat++;
            if (lat == chg_tick) vga_addr = chg_addr;
            if (!flash_ce_n || !flash_oe_n) begin
                low++;
                check("flash_a", {9'd0, flash_a}, {9'd0, a[22:1], 1'b0});
            end
            if (vga_success === 1'b1) got = 1;
        end
        check("latency", lat, W + 1);
        check("enable_cycles", low, W);
        check("vga_data", {16'd0, vga_data}, {16'd0, model(a)});
        last_word = model(a);
    endtask

    task automatic check_hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("hold_success", {31'd0, vga_success}, 32'd1);
            check("hold_ce_n", {31'd0, flash_ce_n}, 32'd1);
            check("hold_data", {16'd0, vga_data}, {16'd0, last_word});
        end
    endtask

    initial begin
        logic [22:0] a;

        // Reset with a pending request
        vga_re = 1'b1; vga_addr = 23'h000010;
        for (int i = 0; i < 3; i++) tick();
        check("rst_success", {31'd0, vga_success}, 32'd0);
        check("rst_data", {16'd0, vga_data}, 32'd0);
        check("rst_ce_n", {31'd0, flash_ce_n}, 32'd1);
        check("rst_oe_n", {31'd0, flash_oe_n}, 32'd1);
        check("rst_rp_n", {31'd0, flash_rp_n}, 32'd0);
        check("rst_we_n", {31'd0, flash_we_n}, 32'd1);
        check("rst_byte_n", {31'd0, flash_byte_n}, 32'd1);
        check("rst_flash_a", {9'd0, flash_a}, 32'd0);

        // Single read
        rst = 1'b0;
        wait_word(23'h000010, -1, 23'd0);
        check("single_data", {16'd0, vga_data}, 32'h0000A5AD);
        check("rp_n_released", {31'd0, flash_rp_n}, 32'd1);
        check_hold(2);

        // Same-word change: only bit 0 moves
        vga_addr = 23'h000020;
        wait_word(23'h000020, -1, 23'd0);
        vga_addr = 23'h000021;
        check_hold(4);

        // Streaming: random window, then the tail up to 480000
        a = 23'(2 * $urandom_range(0, 230000));
        vga_addr = a;
        wait_word(a, -1, 23'd0);
        for (int i = 0; i < 60; i++) begin
            a = a + 23'd2;
            vga_addr = a;
            wait_word(a, -1, 23'd0);
        end
        a = 23'd479880;
        vga_addr = a;
        wait_word(a, -1, 23'd0);
        while (a < 23'd480000) begin
            a = a + 23'd2;
            vga_addr = a;
            wait_word(a, -1, 23'd0);
        end

        // Abort on the second access cycle
        vga_re = 1'b0;
        tick();
        check("drop_success", {31'd0, vga_success}, 32'd0);
        vga_addr = 23'h000030; vga_re = 1'b1;
        tick();
        check("abort_en_low1", {31'd0, flash_oe_n}, 32'd0);
        tick();
        check("abort_en_low2", {31'd0, flash_oe_n}, 32'd0);
        vga_re = 1'b0;
        tick();
        check("abort_ce_n", {31'd0, flash_ce_n}, 32'd1);
        check("abort_oe_n", {31'd0, flash_oe_n}, 32'd1);
        check("abort_data_kept", {16'd0, vga_data}, {16'd0, last_word});
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            check("abort_no_success", {31'd0, vga_success}, 32'd0);
            check("abort_idle_ce_n", {31'd0, flash_ce_n}, 32'd1);
        end
        vga_addr = 23'h000040; vga_re = 1'b1;
        wait_word(23'h000040, -1, 23'd0);

        // Address change mid-access is ignored until the word completes
        vga_re = 1'b0;
        tick();
        vga_addr = 23'h000100; vga_re = 1'b1;
        wait_word(23'h000100, 2, 23'h000200);
        wait_word(23'h000200, -1, 23'd0);

        // Randomized reads: random addresses, holds, bit-0 wiggle, drops
        for (int i = 0; i < 20; i++) begin
            a = 23'($urandom_range(0, 23'h7FFFFF)) & 23'h7FFFFE;
            if (a[22:1] == vga_addr[22:1]) a = a ^ 23'h000002;
            vga_addr = a;
            wait_word(a, -1, 23'd0);
            vga_addr[0] = $urandom_range(0, 1) != 0;
            check_hold($urandom_range(0, 3));
            if ($urandom_range(0, 1) != 0) begin
                vga_re = 1'b0;
                tick();
                check("rand_drop", {31'd0, vga_success}, 32'd0);
                vga_re = 1'b1;
            end
        end

        // Reset in the middle of an access
        vga_re = 1'b0;
        tick();
        vga_addr = 23'h000300; vga_re = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_ce_n", {31'd0, flash_ce_n}, 32'd1);
        check("mid_rst_oe_n", {31'd0, flash_oe_n}, 32'd1);
        check("mid_rst_success", {31'd0, vga_success}, 32'd0);
        check("mid_rst_data", {16'd0, vga_data}, 32'd0);
        check("mid_rst_flash_a", {9'd0, flash_a}, 32'd0);
        check("mid_rst_rp_n", {31'd0, flash_rp_n}, 32'd0);
        rst = 1'b0; vga_re = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("post_rst_idle", {31'd0, vga_success}, 32'd0);
        end
        vga_addr = 23'h000400; vga_re = 1'b1;
        wait_word(23'h000400, -1, 23'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_flash_reader.md
# vga_flash_reader

Read-only word fetcher between the VGA controller's preload port and the board's parallel NOR flash. It accepts the controller's byte-addressed request (`vga_re`/`vga_addr`) and runs one timed 16-bit flash read cycle. It then returns the word on `vga_data` with `vga_success`, holding both stable until the controller moves to another word or drops its request.

## Interface
Parameters:
- `WAIT_CYCLES`, default 5: clock cycles for which `flash_ce_n`/`flash_oe_n` stay low per access. Legal range is 1..15. The default of 100 ns at 50 MHz covers flash tACC.

Ports:
- `clk` in 1: single system clock (50 MHz).
- `rst` in 1: synchronous reset, active-high.
- `vga_re` in 1: read request level from the VGA controller.
- `vga_addr` in 23: byte address; the word address is `vga_addr[22:1]`.
- `vga_data` out 16: registered read word; `[7:0]` is the low-address byte.
- `vga_success` out 1: registered; high while `vga_data` is valid for the current word.
- `flash_a` out 23: flash address, driven as {`addr_q[22:1]`, 1'b0}.
- `flash_d` in 16: flash data bus; this block never drives it.
- `flash_ce_n` out 1: chip enable, active-low.
- `flash_oe_n` out 1: output enable, active-low.
- `flash_we_n` out 1: constant 1.
- `flash_byte_n` out 1: constant 1 (word mode).
- `flash_rp_n` out 1: 0 during `rst`, else 1 (registered).

## Operation
- State machine: IDLE, ACCESS, HOLD. It uses a 4-bit wait counter `cnt` and a 22-bit latched word address `addr_q`.
- **Reset** (any state, takes effect at the next edge):
  - state = IDLE, `cnt` = 0, `addr_q` = 0.
  - `vga_data` = 0, `vga_success` = 0, `flash_a` = 0.
  - `flash_ce_n` = 1, `flash_oe_n` = 1, `flash_rp_n` = 0.
- **IDLE:**
  - `vga_success` = 0; `flash_ce_n`/`flash_oe_n` = 1.
  - If `vga_re` = 1: latch `addr_q` <= `vga_addr[22:1]`, drive `flash_a` from it, set `flash_ce_n`/`flash_oe_n` = 0, `cnt` <= 0, go to ACCESS.
- **ACCESS:**
  - `cnt` increments every edge.
  - At the edge where `cnt` == `WAIT_CYCLES`-1: sample `flash_d` into `vga_data`, set `vga_success` <= 1, set `flash_ce_n`/`flash_oe_n` <= 1, go to HOLD.
  - If `vga_re` = 0 at any ACCESS edge: abort. Enables go high, `vga_success` stays 0, `vga_data` keeps its old value, go to IDLE.
  - Changes on `vga_addr` during ACCESS are ignored. The access completes for `addr_q`.
- **HOLD:**
  - `vga_success` = 1 and `vga_data` is constant.
  - If `vga_re` = 0: `vga_success` <= 0, go to IDLE.
  - Else if `vga_addr[22:1]` != `addr_q`: `vga_success` <= 0 and a new access starts on the same edge (latch, enables low, `cnt` <= 0, ACCESS).
  - Else (same word, including a change in bit 0 only): stay in HOLD.
- Guarantees for the consumer:
  - `vga_success` rises only with valid data.
  - `vga_success` falls for at least `WAIT_CYCLES` cycles between two different words.
  - `vga_data` never changes while `vga_success` = 1.
- No wrap handling is needed. Address arithmetic belongs to the consumer; this block only compares and latches.

## Timing
- Request sampled at edge E0 (IDLE, `vga_re` = 1). Enables are low from E0 through E0+`WAIT_CYCLES`. `flash_d` is sampled at E0+`WAIT_CYCLES`, and `vga_success`/`vga_data` are visible after that edge.
  - Latency = `WAIT_CYCLES` edges (5 with the default).
- Back-to-back words:
  - A new word address seen in HOLD at edge H makes `vga_success` low after H and high again after H+`WAIT_CYCLES`.
  - Throughput is one word per `WAIT_CYCLES`+1 cycles when the consumer advances the address on the first `vga_success` cycle.
- `flash_a` changes only on the edge that enables are asserted, never while `flash_oe_n` = 0. This meets address-to-output setup.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A `rst` pulse mid-ACCESS releases `flash_ce_n`/`flash_oe_n` at the same edge. After reset deasserts, the block returns to IDLE behaviour with no residual `vga_success`.

## Test plan
- **Reset values:** hold `rst` high 3 cycles with `vga_re` = 1 → `vga_success` = 0, `vga_data` = 0x0000, `flash_ce_n` = `flash_oe_n` = 1, `flash_rp_n` = 0, `flash_we_n` = `flash_byte_n` = 1.
- **Single read:** flash model returns word = `addr[16:1]` ^ 0xA5A5; `vga_re` = 1, `vga_addr` = 0x000010.
  - `vga_success` rises exactly 5 edges after the request is sampled, with `vga_data` = 0xA5AD.
  - `flash_a` = 0x000010; enables are low for exactly 5 cycles.
- **Streaming like the VGA controller:** the consumer adds 2 to `vga_addr` on the first `vga_success` cycle, 0 → 480000.
  - Every word matches the model, `vga_success` drops for ≥5 cycles between words, and `vga_data` is stable during each `vga_success` window.
- **Same-word change:** in HOLD, change `vga_addr` 0x000020 → 0x000021 → `vga_success` stays 1, no new flash cycle starts, `vga_data` is unchanged.
- **Abort:** drop `vga_re` at the 2nd ACCESS cycle → enables go high on the next edge, `vga_success` never asserts, the FSM is in IDLE. A fresh request to 0x000040 then completes normally.
- **Address change mid-access and reset mid-access:**
  - Change `vga_addr` 0x100 → 0x200 during ACCESS → the first result is for 0x100. `vga_success` then drops for ≥5 cycles and a second read of 0x200 follows.
  - Assert `rst` mid-ACCESS → enables release on the same edge and all outputs match the reset values.
